// File: rtl/md_pkg.sv
// md_pkg: shared FSM state type plus width and legality helpers for the MD interface.
package md_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2
    } md_state_t;

    function automatic int md_offset_w(input int width);
        int w;
        w = $clog2(width / 8);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int md_size_w(input int width);
        return $clog2(width / 8) + 1;
    endfunction

    function automatic logic md_cfg_legal(input int offset, input int size, input int width);
        return (size != 0) && (offset + size <= width / 8);
    endfunction

endpackage

// File: rtl/md_packer.sv
// md_packer: packs a valid/ready byte stream into one MD transfer per chunk
// at a configured lane offset/size, and counts completed and errored transfers.
module md_packer
    import md_pkg::*;
#(
    parameter int ALGN_DATA_WIDTH = 32,
    parameter int OFFSET_W        = md_offset_w(ALGN_DATA_WIDTH),
    parameter int SIZE_W          = md_size_w(ALGN_DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [OFFSET_W-1:0]        cfg_offset,
    input  logic [SIZE_W-1:0]          cfg_size,
    output logic                       cfg_illegal,
    input  logic                       s_valid,
    input  logic [7:0]                 s_data,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic                       md_valid,
    output logic [ALGN_DATA_WIDTH-1:0] md_data,
    output logic [OFFSET_W-1:0]        md_offset,
    output logic [SIZE_W-1:0]          md_size,
    input  logic                       md_ready,
    input  logic                       md_err,
    output logic [15:0]                tx_cnt,
    output logic [15:0]                err_cnt
);

    localparam int LANES = ALGN_DATA_WIDTH / 8;

    md_state_t                  state_q, state_d;
    logic [OFFSET_W-1:0]        off_q, off_d;
    logic [SIZE_W-1:0]          sz_q, sz_d;
    logic [SIZE_W-1:0]          cnt_q, cnt_d;
    logic [ALGN_DATA_WIDTH-1:0] data_q, data_d;
    logic                       md_valid_q, md_valid_d;
    logic [15:0]                tx_cnt_q, tx_cnt_d;
    logic [15:0]                err_cnt_q, err_cnt_d;
    logic [SIZE_W:0]            cfg_end;
    logic [SIZE_W:0]            wr_idx;
    logic                       accept;
    logic                       done;

    // One extra bit keeps offset+size from wrapping back into the legal range.
    always_comb begin
        cfg_end     = {1'b0, cfg_size} + (SIZE_W+1)'(cfg_offset);
        cfg_illegal = (cfg_size == '0) || (cfg_end > (SIZE_W+1)'(LANES));
    end

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        sz_d       = sz_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        md_valid_d = md_valid_q;
        tx_cnt_d   = tx_cnt_q;
        err_cnt_d  = err_cnt_q;
        s_ready    = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        wr_idx     = '0;

        case (state_q)
            IDLE: begin
                s_ready = reset_n && !cfg_illegal;
                accept  = s_valid && s_ready;
                wr_idx  = (SIZE_W+1)'(cfg_offset);
                if (accept) begin
                    off_d   = cfg_offset;
                    sz_d    = cfg_size;
                    cnt_d   = SIZE_W'(1);
                    data_d  = '0;
                    state_d = FILL;
                    done    = (cfg_size == SIZE_W'(1)) || s_last;
                end
            end
            FILL: begin
                s_ready = reset_n;
                accept  = s_valid && s_ready;
                wr_idx  = (SIZE_W+1)'(off_q) + (SIZE_W+1)'(cnt_q);
                if (accept) begin
                    cnt_d = cnt_q + SIZE_W'(1);
                    done  = (cnt_d == sz_q) || s_last;
                end
            end
            SEND: begin
                if (md_ready) begin
                    state_d    = IDLE;
                    md_valid_d = 1'b0;
                    if (tx_cnt_q != 16'hFFFF) tx_cnt_d = tx_cnt_q + 16'd1;
                    if (md_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Byte-lane write decoder: only the lane at off+cnt takes the byte.
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_idx == (SIZE_W+1)'(i)) data_d[i*8 +: 8] = s_data;
            end
        end

        if (done) begin
            state_d    = SEND;
            md_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            off_q      <= '0;
            sz_q       <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            md_valid_q <= 1'b0;
            tx_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            sz_q       <= sz_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            md_valid_q <= md_valid_d;
            tx_cnt_q   <= tx_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign md_valid  = md_valid_q;
    assign md_data   = data_q;
    assign md_offset = off_q;
    assign md_size   = cnt_q;
    assign tx_cnt    = tx_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_md_packer.sv
// tb_md_packer: directed and randomized bench for md_packer with a chunking
// reference model and a bus monitor acting as the MD sink.
module tb_md_packer;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  off;
        logic [2:0]  size;
        logic        err;
    } xfer_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  cfg_offset;
    logic [2:0]  cfg_size;
    logic        cfg_illegal;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        md_valid;
    logic [31:0] md_data;
    logic [1:0]  md_offset;
    logic [2:0]  md_size;
    logic        md_ready;
    logic        md_err;
    logic [15:0] tx_cnt;
    logic [15:0] err_cnt;

    logic        rand_rdy, rdy_rnd, rdy_man;
    int          errors, checks;
    int          exp_tx, exp_err;

    xfer_t       mon_q[$];
    xfer_t       exp_q[$];
    int          vld_cycles, hold_viol;
    logic        held;
    logic [31:0] h_data;
    logic [1:0]  h_off;
    logic [2:0]  h_size;

    md_packer #(.ALGN_DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_offset(cfg_offset), .cfg_size(cfg_size), .cfg_illegal(cfg_illegal),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .md_valid(md_valid), .md_data(md_data), .md_offset(md_offset), .md_size(md_size),
        .md_ready(md_ready), .md_err(md_err),
        .tx_cnt(tx_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign md_ready = rand_rdy ? rdy_rnd : rdy_man;
    always @(negedge clk) rdy_rnd <= 1'($urandom_range(0, 1));

    // MD sink monitor: records completed transfers and flags unstable held outputs.
    initial begin
        vld_cycles = 0;
        hold_viol  = 0;
        held       = 1'b0;
    end
    always @(posedge clk) begin
        if (reset_n && md_valid) begin
            vld_cycles <= vld_cycles + 1;
            if (held && (md_data !== h_data || md_offset !== h_off || md_size !== h_size))
                hold_viol <= hold_viol + 1;
            if (md_ready) begin
                mon_q.push_back('{md_data, md_offset, md_size, md_err});
                held <= 1'b0;
            end else begin
                held   <= 1'b1;
                h_data <= md_data;
                h_off  <= md_offset;
                h_size <= md_size;
            end
        end else begin
            held <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic last, output int waited);
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        #1;
        while (!s_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, waited);
        end else begin
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        cfg_offset = 2'd0; cfg_size = 3'd1; md_err = 1'b0;
        rand_rdy = 1'b0; rdy_man = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0b want 0", s_ready); end
        checks++; if (md_valid !== 1'b0) begin errors++; $display("FAIL rst_md_valid: got %0b want 0", md_valid); end
        checks++; if (md_data !== 32'h0) begin errors++; $display("FAIL rst_md_data: got %h want 0", md_data); end
        checks++; if (md_offset !== 2'd0 || md_size !== 3'd0) begin errors++; $display("FAIL rst_off_size: got %0d/%0d want 0/0", md_offset, md_size); end
        checks++; if (tx_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d want 0/0", tx_cnt, err_cnt); end
        reset_n = 1'b1; exp_tx = 0; exp_err = 0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", s_ready); end
    endtask

    task automatic test_normal();
        int w, base, v0;
        rdy_man = 1'b1; cfg_offset = 2'd1; cfg_size = 3'd2;
        base = mon_q.size(); v0 = vld_cycles;
        send_byte(8'hAA, 1'b0, w);
        send_byte(8'hBB, 1'b0, w);
        checks++; if (md_valid !== 1'b1) begin errors++; $display("FAIL norm_valid: got %0b want 1", md_valid); end
        checks++; if (md_data !== 32'h00BBAA00) begin errors++; $display("FAIL norm_data: got %h want 00bbaa00", md_data); end
        checks++; if (md_offset !== 2'd1 || md_size !== 3'd2) begin errors++; $display("FAIL norm_off_size: got %0d/%0d want 1/2", md_offset, md_size); end
        @(negedge clk);
        exp_tx++;
        checks++; if (md_valid !== 1'b0) begin errors++; $display("FAIL norm_valid_drop: got %0b want 0", md_valid); end
        checks++; if (tx_cnt !== 16'(exp_tx)) begin errors++; $display("FAIL norm_tx_cnt: got %0d want %0d", tx_cnt, exp_tx); end
        checks++; if (vld_cycles - v0 != 1 || mon_q.size() - base != 1) begin errors++; $display("FAIL norm_one_cycle: got %0d valid cycles %0d xfers want 1 1", vld_cycles - v0, mon_q.size() - base); end
    endtask

    task automatic test_short_backpressure();
        int w;
        rdy_man = 1'b0; cfg_offset = 2'd0; cfg_size = 3'd4;
        send_byte(8'h11, 1'b0, w);
        send_byte(8'h22, 1'b1, w);
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (md_valid !== 1'b1 || md_data !== 32'h00002211 || md_size !== 3'd2 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_c%0d: got v=%0b d=%h sz=%0d rdy=%0b want 1 00002211 2 0", c, md_valid, md_data, md_size, s_ready);
            end
            @(negedge clk);
        end
        rdy_man = 1'b1;
        checks++; if (md_valid !== 1'b1 || tx_cnt !== 16'(exp_tx)) begin errors++; $display("FAIL bp_c6_pending: got v=%0b tx=%0d want 1 %0d", md_valid, tx_cnt, exp_tx); end
        @(negedge clk);
        exp_tx++;
        checks++; if (md_valid !== 1'b0 || tx_cnt !== 16'(exp_tx)) begin errors++; $display("FAIL bp_complete: got v=%0b tx=%0d want 0 %0d", md_valid, tx_cnt, exp_tx); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d hold violations want 0", hold_viol); end
    endtask

    task automatic test_illegal();
        int w;
        logic want;
        rdy_man = 1'b1;
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 8; s++) begin
                cfg_offset = 2'(o); cfg_size = 3'(s);
                #1;
                want = !(s != 0 && o + s <= 4);
                checks++;
                if (cfg_illegal !== want || s_ready !== !want) begin
                    errors++;
                    $display("FAIL ill_sweep_o%0d_s%0d: got ill=%0b rdy=%0b want %0b %0b", o, s, cfg_illegal, s_ready, want, !want);
                end
            end
        end
        @(negedge clk);
        cfg_offset = 2'd3; cfg_size = 3'd2; #1;
        checks++; if (cfg_illegal !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL ill_3_2: got ill=%0b rdy=%0b want 1 0", cfg_illegal, s_ready); end
        cfg_size = 3'd1; #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ill_fix_ready: got %0b want 1", s_ready); end
        send_byte(8'h5A, 1'b0, w);
        checks++; if (md_valid !== 1'b1 || md_data !== 32'h5A000000 || md_offset !== 2'd3 || md_size !== 3'd1) begin
            errors++; $display("FAIL ill_xfer: got v=%0b d=%h o=%0d s=%0d want 1 5a000000 3 1", md_valid, md_data, md_offset, md_size);
        end
        @(negedge clk);
        exp_tx++;
    endtask

    task automatic test_error();
        int w, base;
        logic e;
        rdy_man = 1'b1; cfg_offset = 2'd0; cfg_size = 3'd1;
        base = mon_q.size();
        for (int k = 0; k < 4; k++) begin
            send_byte(8'(k + 1), 1'b0, w);
            e = (k == 1 || k == 3);
            md_err = e;
            @(negedge clk);
            md_err = 1'b0;
            exp_tx++;
            if (e) exp_err++;
        end
        checks++; if (tx_cnt !== 16'(exp_tx) || err_cnt !== 16'(exp_err)) begin errors++; $display("FAIL err_counts: got %0d/%0d want %0d/%0d", tx_cnt, err_cnt, exp_tx, exp_err); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mon_q.size() <= base + k || mon_q[base+k].data !== 32'(k + 1)) begin
                errors++; $display("FAIL err_xfer%0d: transfer missing or wrong data, want %h", k, 32'(k + 1));
            end
        end
        rdy_man = 1'b0;
        send_byte(8'h77, 1'b0, w);
        md_err = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (err_cnt !== 16'(exp_err) || md_valid !== 1'b1) begin errors++; $display("FAIL err_no_ready: got err=%0d v=%0b want %0d 1", err_cnt, md_valid, exp_err); end
        md_err = 1'b0; rdy_man = 1'b1;
        @(negedge clk);
        exp_tx++;
        checks++; if (tx_cnt !== 16'(exp_tx) || err_cnt !== 16'(exp_err)) begin errors++; $display("FAIL err_final: got %0d/%0d want %0d/%0d", tx_cnt, err_cnt, exp_tx, exp_err); end
    endtask

    task automatic test_back_to_back();
        int w, base;
        int waits[8];
        rdy_man = 1'b1; cfg_offset = 2'd0; cfg_size = 3'd4;
        base = mon_q.size();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h10 + 8'(i), 1'b0, w);
            waits[i] = w;
        end
        @(negedge clk);
        exp_tx += 2;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (waits[i] != ((i == 4) ? 1 : 0)) begin errors++; $display("FAIL b2b_gap_b%0d: got %0d stall cycles want %0d", i, waits[i], (i == 4) ? 1 : 0); end
        end
        checks++;
        if (mon_q.size() - base != 2) begin
            errors++; $display("FAIL b2b_count: got %0d transfers want 2", mon_q.size() - base);
        end else begin
            checks++; if (mon_q[base].data !== 32'h13121110 || mon_q[base].err !== 1'b0) begin errors++; $display("FAIL b2b_x0: got %h want 13121110", mon_q[base].data); end
            checks++; if (mon_q[base+1].data !== 32'h17161514 || mon_q[base+1].err !== 1'b0) begin errors++; $display("FAIL b2b_x1: got %h want 17161514", mon_q[base+1].data); end
        end
    endtask

    task automatic test_random();
        int cur_off, cur_sz, len, n, w, base, cnt;
        logic [31:0] acc;
        logic [7:0]  b;
        logic        last;
        xfer_t       e;
        for (int r = 0; r < 4; r++) begin
            rand_rdy = 1'b1; len = 0; acc = '0; cur_off = 0; cur_sz = 1;
            n = $urandom_range(12, 30);
            base = mon_q.size();
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                if (len == 0) begin
                    cur_off = $urandom_range(0, 3);
                    cur_sz  = $urandom_range(1, 4 - cur_off);
                    cfg_offset = 2'(cur_off); cfg_size = 3'(cur_sz);
                end
                b    = 8'($urandom);
                last = (i == n - 1) || ($urandom_range(0, 4) == 0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(b, last, w);
                acc = acc | (32'(b) << (8 * (cur_off + len)));
                len++;
                if (len == cur_sz || last) begin
                    e.data = acc; e.off = 2'(cur_off); e.size = 3'(len); e.err = 1'b0;
                    exp_q.push_back(e);
                    acc = '0; len = 0;
                end else begin
                    // Mid-chunk config changes must not affect the chunk in flight.
                    cfg_offset = 2'($urandom); cfg_size = 3'($urandom);
                end
            end
            cnt = 0;
            while (mon_q.size() - base < exp_q.size() && cnt < 400) begin
                @(negedge clk);
                cnt++;
            end
            rand_rdy = 1'b0; rdy_man = 1'b1;
            @(negedge clk);
            exp_tx += exp_q.size();
            checks++;
            if (mon_q.size() - base != exp_q.size()) begin
                errors++; $display("FAIL rnd%0d_count: got %0d transfers want %0d", r, mon_q.size() - base, exp_q.size());
            end else begin
                foreach (exp_q[k]) begin
                    checks++;
                    if (mon_q[base+k].data !== exp_q[k].data || mon_q[base+k].off !== exp_q[k].off || mon_q[base+k].size !== exp_q[k].size) begin
                        errors++;
                        $display("FAIL rnd%0d_x%0d: got %h/%0d/%0d want %h/%0d/%0d", r, k, mon_q[base+k].data, mon_q[base+k].off, mon_q[base+k].size, exp_q[k].data, exp_q[k].off, exp_q[k].size);
                    end
                end
            end
            checks++; if (tx_cnt !== 16'(exp_tx)) begin errors++; $display("FAIL rnd%0d_tx_cnt: got %0d want %0d", r, tx_cnt, exp_tx); end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL rnd_hold_stable: got %0d violations want 0", hold_viol); end
    endtask

    task automatic test_reset_mid();
        int w, base, v0;
        rdy_man = 1'b1; cfg_offset = 2'd0; cfg_size = 3'd4;
        v0 = vld_cycles;
        send_byte(8'hA1, 1'b0, w);
        send_byte(8'hA2, 1'b0, w);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; exp_tx = 0; exp_err = 0;
        checks++; if (tx_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rmid_counters: got %0d/%0d want 0/0", tx_cnt, err_cnt); end
        checks++; if (md_valid !== 1'b0 || vld_cycles != v0) begin errors++; $display("FAIL rmid_no_valid: got v=%0b cycles=%0d want 0 0", md_valid, vld_cycles - v0); end
        base = mon_q.size();
        send_byte(8'h01, 1'b0, w);
        send_byte(8'h02, 1'b0, w);
        send_byte(8'h03, 1'b0, w);
        send_byte(8'h04, 1'b0, w);
        checks++; if (md_valid !== 1'b1 || md_data !== 32'h04030201 || md_size !== 3'd4) begin errors++; $display("FAIL rmid_xfer: got v=%0b d=%h s=%0d want 1 04030201 4", md_valid, md_data, md_size); end
        @(negedge clk);
        exp_tx++;
        checks++; if (mon_q.size() - base != 1 || tx_cnt !== 16'(exp_tx)) begin errors++; $display("FAIL rmid_count: got %0d xfers tx=%0d want 1 %0d", mon_q.size() - base, tx_cnt, exp_tx); end
    endtask

    initial begin
        errors = 0; checks = 0; exp_tx = 0; exp_err = 0;
        rand_rdy = 1'b0; rdy_man = 1'b1; md_err = 1'b0;
        reset_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        cfg_offset = 2'd0; cfg_size = 3'd1;
        @(negedge clk);
        test_reset();
        test_normal();
        test_short_backpressure();
        test_illegal();
        test_error();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_packer.md
# md_packer

Byte-stream to MD-protocol transmitter. Accepts bytes on a simple valid/ready stream, packs them into one MD transfer per chunk at a configured lane offset and size, then drives the transfer on an MD bus into the `md_rx_*` port of `cfs_aligner`. It is the synthesizable source end of the MD interface that the aligner receives on. It also counts completed transfers and transfers the aligner answered with an error.

## Interface
- `ALGN_DATA_WIDTH`, default 32: MD data width in bits. Legal values are 8, 16, 32, 64 and so on, in powers of two.
- `OFFSET_W`, derived as `$clog2(ALGN_DATA_WIDTH/8)`, with a minimum of 1: width of the offset field.
- `SIZE_W`, derived as `$clog2(ALGN_DATA_WIDTH/8)+1`: width of the size field.
- `clk` in, 1 bit: the single clock.
- `reset_n` in, 1 bit: synchronous, active-low reset.
- `cfg_offset` in, `OFFSET_W` bits: byte lane where a chunk starts.
- `cfg_size` in, `SIZE_W` bits: bytes per chunk.
- `cfg_illegal` out, 1 bit: the current configuration is illegal.
- `s_valid` in, 1 bit: input byte valid.
- `s_data` in, 8 bits: input byte.
- `s_last` in, 1 bit: this byte ends the packet and forces a short chunk.
- `s_ready` out, 1 bit: the packer accepts the byte this cycle.
- `md_valid` out, 1 bit: MD transfer valid.
- `md_data` out, `ALGN_DATA_WIDTH` bits: MD data.
- `md_offset` out, `OFFSET_W` bits: MD offset.
- `md_size` out, `SIZE_W` bits: MD size.
- `md_ready` in, 1 bit: MD handshake.
- `md_err` in, 1 bit: the sink reports an error. It is sampled only when `md_valid && md_ready`.
- `tx_cnt` out, 16 bits: completed MD transfers. Saturates.
- `err_cnt` out, 16 bits: completed transfers that carried `md_err`. Saturates.

## Operation
- **Legal configuration:**
  - `cfg_size` must be non-zero.
  - `cfg_offset + cfg_size` must be at most `ALGN_DATA_WIDTH/8`.
  - The sum is computed at `SIZE_W+1` bits so it cannot overflow.
  - `cfg_illegal` is combinational on the live `cfg_*` inputs.
- **Configuration latch:** the configuration is latched when the first byte of a chunk is accepted. Changes to `cfg_*` mid-chunk have no effect until the next chunk.
- **FSM states:** IDLE, FILL and SEND.
- **IDLE:**
  - `s_ready = !cfg_illegal`.
  - On accept: latch `off`/`sz`, write the byte to lane `off`, and set `cnt = 1`.
  - If `sz == 1` or `s_last` is set, go to SEND. Otherwise go to FILL.
- **FILL:**
  - `s_ready = 1`.
  - On accept: write the byte to lane `off + cnt`, then increment `cnt`.
  - If the new `cnt == sz` or `s_last` is set, go to SEND.
- **SEND:**
  - `md_valid = 1` and `s_ready = 0`.
  - `md_offset = off`, `md_size = cnt`.
  - `md_data` holds the packed bytes. Lanes outside `[off, off+cnt)` are driven 0.
  - All MD outputs stay stable until the handshake completes.
  - On `md_ready`: increment `tx_cnt`; increment `err_cnt` if `md_err` is set; go to IDLE.
- **Counters:** both saturate at 16'hFFFF.
- **Packet boundaries:** `s_last` only shortens the current chunk. There is no packet state across chunks.
- **Reset values:**
  - `md_valid = 0`, `md_data = 0`, `md_offset = 0`, `md_size = 0`.
  - `s_ready = 0` during reset.
  - `tx_cnt = 0`, `err_cnt = 0`.
  - The FSM is in IDLE with `cnt = 0`.
- **Reset mid-operation:** the partial chunk, or the pending transfer, is discarded. `md_valid` falls at the reset edge. This is the one allowed exception to the MD hold rule.

## Timing
- All MD outputs come from registers. `s_ready` and `cfg_illegal` are combinational from the state and the `cfg_*` inputs.
- The byte that completes a chunk is accepted at edge N. `md_valid` is then high from N+1.
- A handshake at edge M (`md_valid && md_ready`) returns the FSM to IDLE for cycle M+1. `md_valid` is low in M+1, and `s_ready` may be high in M+1.
- Peak throughput is one chunk per `sz + 1` cycles when `md_ready` is tied high.
- **`md_ready` already high when SEND is entered:** the transfer completes in the first SEND cycle.
- **`md_ready` low:** the transfer holds indefinitely. No byte is accepted meanwhile.
- **Simultaneous events:** `s_last` together with `cnt + 1 == sz` gives one chunk of size `sz`. A zero-length chunk is never produced.
- **`md_err` without `md_ready`:** ignored.

## Structure
- Shared package `md_pkg`:
  - `md_state_t` enum: IDLE, FILL, SEND.
  - Functions `md_offset_w(width)` and `md_size_w(width)`.
  - Function `md_cfg_legal(offset, size, width)`. The bench scoreboard and `cfs_aligner` checkers reuse it.
- No sub-module. The block is one module with:
  - the FSM;
  - a byte-lane write decoder, implemented as a loop over lanes comparing against `off + cnt`;
  - two saturating counters.

## Test plan
- **Normal chunk:** W=32, offset=1, size=2. Bytes 0xAA, 0xBB, with `md_ready` held high. Expect one transfer with `md_data = 0x00BBAA00`, `md_offset = 1`, `md_size = 2`; `md_valid` high exactly 1 cycle, starting the cycle after 0xBB is accepted; `tx_cnt = 1`.
- **Short chunk and back-pressure:** offset=0, size=4. Bytes 0x11, 0x22 with `s_last` on 0x22, and `md_ready` low for 5 cycles. Expect `md_data = 0x00002211` and `md_size = 2`, held stable for 5 cycles with `s_ready = 0`; completion on the 6th.
- **Illegal configuration:** offset=3, size=2. Expect `cfg_illegal = 1` and `s_ready = 0`. Change to size=1 and expect `s_ready = 1` in the same cycle. Byte 0x5A then gives `md_data = 0x5A000000`.
- **Error response:** offset=0, size=1, 4 bytes, with `md_err` high on transfers 2 and 4. Expect `tx_cnt = 4` and `err_cnt = 2`. A further `md_err` pulse with `md_ready` low leaves `err_cnt = 2`.
- **Reset mid-operation:** offset=0, size=4. Accept 2 bytes, then assert `reset_n = 0` for 1 cycle. Expect `md_valid` never asserted, counters at 0, and the next 4 bytes 01 02 03 04 to give `md_data = 0x04030201`.
- **Back-to-back against `cfs_aligner`:** offset=0, size=4, 8 bytes streamed continuously. Expect 2 transfers on the aligner's `md_rx_*` inputs, no `md_rx_err`, and `s_ready` low exactly one cycle between chunks.
